// File: rtl/ysyx_23060061_pkg.sv
// ysyx_23060061_pkg: shared IFU state encoding and reset/instruction constants
package ysyx_23060061_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_ZERO        = 32'h0000_0000;

endpackage

// File: rtl/ysyx_23060061_ifu.sv
// ysyx_23060061_ifu: single-outstanding instruction fetch unit (IDLE/REQ/WAIT/HOLD);
// define YSYX_23060061_IFU_ALIGN_CHECK_EN to fault misaligned pcs without issuing a request
module ysyx_23060061_ifu
    import ysyx_23060061_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [AW-1:0] req_addr,
    input  logic          rsp_valid,
    input  logic [AW-1:0] rsp_data,
    input  logic          rsp_err,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [AW-1:0] inst,
    output logic [AW-1:0] pc,
    output logic          fault,
    input  logic [AW-1:0] dnpc
);

    ifu_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] inst_q, inst_d;
    logic          fault_q, fault_d;
    logic          misalign;
    logic          bad_pc;
    logic          take_rsp;

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
    assign misalign = pc_q[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif

    assign bad_pc   = (state_q == REQ) && misalign;
    assign take_rsp = (state_q == WAIT) && rsp_valid;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // next state: responses only count in WAIT, request ready only while requesting
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = misalign ? HOLD : (req_ready ? WAIT : REQ);
            WAIT:    state_d = rsp_valid ? HOLD : WAIT;
            HOLD:    state_d = inst_ready ? REQ : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state; a misaligned pc never reaches the bus
    always_comb begin
        req_valid  = (state_q == REQ) && !misalign;
        inst_valid = state_q == HOLD;
    end

    // datapath next values: capture response, fault on bus error or bad pc, advance pc on handshake
    always_comb begin
        pc_d    = (state_q == HOLD && inst_ready) ? dnpc : pc_q;
        inst_d  = bad_pc ? AW'(INST_ZERO) : take_rsp ? (rsp_err ? AW'(INST_ZERO) : rsp_data) : inst_q;
        fault_d = bad_pc ? 1'b1 : take_rsp ? rsp_err : fault_q;
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    assign req_addr = pc_q;
    assign pc       = pc_q;
    assign inst     = inst_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// tb_ysyx_23060061_ifu: directed self-checking bench for the fetch unit
module tb_ysyx_23060061_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] dnpc;

    int checks = 0;
    int errors = 0;
    int hs     = 0;

    ysyx_23060061_ifu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .fault      (fault),
        .dnpc       (dnpc)
    );

    always #5 clk = ~clk;

    // count accepted requests on the bus
    always @(posedge clk) if (rst && req_valid && req_ready) hs++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        rsp_err = 1'b0; inst_ready = 1'b0; dnpc = '0;
        repeat (2) nxt();
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst", inst, 32'h0);
        chk1("rst_fault", fault, 1'b0);
        // release reset: one IDLE cycle, then REQ with immediate acceptance
        rst = 1'b1; req_ready = 1'b1;
        #1 chk1("idle_req_valid", req_valid, 1'b0);
        nxt();
        chk1("req1_valid", req_valid, 1'b1);
        chk("req1_addr", req_addr, 32'h8000_0000);
        nxt();
        chk1("wait1_req_valid", req_valid, 1'b0);
        chk1("wait1_inst_valid", inst_valid, 1'b0);
        rsp_valid = 1'b1; rsp_data = 32'h0010_0073; req_ready = 1'b0;
        nxt();
        rsp_valid = 1'b0;
        chk1("hold1_inst_valid", inst_valid, 1'b1);
        chk("hold1_inst", inst, 32'h0010_0073);
        chk1("hold1_fault", fault, 1'b0);
        chk("hold1_pc", pc, 32'h8000_0000);
        // stall the core with a spurious response in HOLD
        for (int i = 0; i < 4; i++) begin
            rsp_valid = 1'b1; rsp_data = 32'hdead_beef; rsp_err = 1'b1;
            nxt();
            chk1("stall_inst_valid", inst_valid, 1'b1);
            chk("stall_inst", inst, 32'h0010_0073);
            chk("stall_pc", pc, 32'h8000_0000);
            chk1("stall_fault", fault, 1'b0);
        end
        rsp_valid = 1'b0; rsp_err = 1'b0; inst_ready = 1'b1; dnpc = 32'h8000_0010;
        nxt();
        inst_ready = 1'b0;
        chk1("req2_valid", req_valid, 1'b1);
        chk("req2_addr", req_addr, 32'h8000_0010);
        chk1("req2_inst_valid", inst_valid, 1'b0);
        // memory not ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk1("bp_req_valid", req_valid, 1'b1);
            chk("bp_req_addr", req_addr, 32'h8000_0010);
        end
        req_ready = 1'b1;
        nxt();
        req_ready = 1'b0;
        chk1("wait2_req_valid", req_valid, 1'b0);
        chk("hs_after_bp", 32'(hs), 32'd2);
        repeat (2) nxt();
        chk1("wait2_hold_req_valid", req_valid, 1'b0);
        chk1("wait2_hold_inst_valid", inst_valid, 1'b0);
        // bus error response
        rsp_valid = 1'b1; rsp_err = 1'b1; rsp_data = 32'h1234_5678;
        nxt();
        rsp_valid = 1'b0; rsp_err = 1'b0;
        chk1("err_inst_valid", inst_valid, 1'b1);
        chk("err_inst", inst, 32'h0);
        chk1("err_fault", fault, 1'b1);
        // new request, then reset during WAIT
        inst_ready = 1'b1; dnpc = 32'h8000_0020;
        nxt();
        inst_ready = 1'b0; req_ready = 1'b1;
        chk("req3_addr", req_addr, 32'h8000_0020);
        nxt();
        req_ready = 1'b0;
        chk1("wait3_req_valid", req_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h8000_0000);
        chk1("arst_fault", fault, 1'b0);
        chk1("arst_inst_valid", inst_valid, 1'b0);
        nxt();
        rst = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hcafe_babe;
        nxt();
        chk1("post_rst_req_valid", req_valid, 1'b1);
        chk("post_rst_addr", req_addr, 32'h8000_0000);
        chk1("post_rst_inst_valid", inst_valid, 1'b0);
        chk("post_rst_inst", inst, 32'h0);
        nxt();
        chk1("stale_ignored", inst_valid, 1'b0);
        rsp_valid = 1'b0; req_ready = 1'b1;
        nxt();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
        nxt();
        rsp_valid = 1'b0;
        chk("fresh_inst", inst, 32'h0000_0013);
        chk1("fresh_inst_valid", inst_valid, 1'b1);
        // misaligned next pc
        inst_ready = 1'b1; dnpc = 32'h8000_0006;
        nxt();
        inst_ready = 1'b0; req_ready = 1'b1;
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
        chk1("mis_req_valid", req_valid, 1'b0);
        nxt();
        req_ready = 1'b0;
        chk1("mis_inst_valid", inst_valid, 1'b1);
        chk1("mis_fault", fault, 1'b1);
        chk("mis_inst", inst, 32'h0);
        chk("hs_total", 32'(hs), 32'd4);
`else
        chk1("mis_req_valid", req_valid, 1'b1);
        chk("mis_req_addr", req_addr, 32'h8000_0006);
        nxt();
        req_ready = 1'b0;
        chk1("mis_wait_inst_valid", inst_valid, 1'b0);
        chk("hs_total", 32'(hs), 32'd5);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
